// File: rtl/imem_loader.sv
// imem_loader: loads a program into the instruction memory from a byte stream.
// Bytes are packed little-endian into 32-bit words and written one word per
// WRITE cycle. The core stays stalled until a halt word, or the last memory
// word, has been written.
// Optional build macro IMEM_LOADER_CLEAR_EN: every load first zeroes the
// whole memory, so words the image does not cover read as zero.
module imem_loader #(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned ADDR_W      = 10,
  parameter logic [6:0]  HALT_OPCODE = 7'b1111111
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              cpu_stall,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W:0]   word_count
);

  localparam int unsigned       CNT_W     = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

`ifdef IMEM_LOADER_CLEAR_EN
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RECV  = 3'd1,
    WRITE = 3'd2,
    DONE  = 3'd3,
    CLEAR = 3'd4
  } state_e;
  localparam state_e LOAD_ENTRY = CLEAR;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RECV  = 3'd1,
    WRITE = 3'd2,
    DONE  = 3'd3
  } state_e;
  localparam state_e LOAD_ENTRY = RECV;
`endif

  state_e            state_q, state_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic [CNT_W-1:0]  word_count_q, word_count_d;
  logic              done_q, done_d;
  logic              overflow_q, overflow_d;
  logic              in_ready_q, in_ready_d;
  logic              wr_en_q, wr_en_d;
  logic              cpu_stall_q, cpu_stall_d;

  // State register and registered outputs, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      byte_cnt_q   <= '0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      word_count_q <= '0;
      done_q       <= 1'b0;
      overflow_q   <= 1'b0;
      in_ready_q   <= 1'b0;
      wr_en_q      <= 1'b0;
      cpu_stall_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      word_count_q <= word_count_d;
      done_q       <= done_d;
      overflow_q   <= overflow_d;
      in_ready_q   <= in_ready_d;
      wr_en_q      <= wr_en_d;
      cpu_stall_q  <= cpu_stall_d;
    end
  end

  // Next-state logic; strobes are derived from the next state so they line up
  // with the state they belong to.
  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    word_count_d = word_count_q;
    done_d       = done_q;
    overflow_d   = overflow_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d      = LOAD_ENTRY;
          wr_addr_d    = '0;
          word_count_d = '0;
          byte_cnt_d   = '0;
          done_d       = 1'b0;
          overflow_d   = 1'b0;
`ifdef IMEM_LOADER_CLEAR_EN
          wr_data_d    = '0;
`endif
        end
      end
`ifdef IMEM_LOADER_CLEAR_EN
      CLEAR: begin
        if (wr_addr_q == LAST_ADDR) begin
          state_d   = RECV;
          wr_addr_d = '0;
        end else begin
          wr_addr_d = wr_addr_q + ADDR_W'(1);
        end
      end
`endif
      RECV: begin
        if (in_valid && in_ready_q) begin
          wr_data_d[{byte_cnt_q, 3'b000} +: 8] = in_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        word_count_d = word_count_q + CNT_W'(1);
        if (wr_data_q[6:0] == HALT_OPCODE) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else if (wr_addr_q == LAST_ADDR) begin
          state_d    = DONE;
          done_d     = 1'b1;
          overflow_d = 1'b1;
        end else begin
          state_d    = RECV;
          wr_addr_d  = wr_addr_q + ADDR_W'(1);
          byte_cnt_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    in_ready_d  = (state_d == RECV);
`ifdef IMEM_LOADER_CLEAR_EN
    wr_en_d     = (state_d == WRITE) || (state_d == CLEAR);
`else
    wr_en_d     = (state_d == WRITE);
`endif
    cpu_stall_d = (state_d != IDLE) && (state_d != DONE);
  end

  assign in_ready   = in_ready_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign cpu_stall  = cpu_stall_q;
  assign done       = done_q;
  assign overflow   = overflow_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a 4-word memory.
// Also builds with IMEM_LOADER_CLEAR_EN, where each load is preceded by DEPTH
// zero writes.
module tb_imem_loader;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 2;
`ifdef IMEM_LOADER_CLEAR_EN
  localparam int CLR = DEPTH;
`else
  localparam int CLR = 0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              cpu_stall;
  logic              done;
  logic              overflow;
  logic [ADDR_W:0]   word_count;

  int total = 0;
  int bad   = 0;

  // Byte source: stream[pos] is presented until the handshake consumes it.
  logic [7:0]  stream[$];
  int          pos = 0;
  int          cyc = 0;
  bit          toggle = 1'b0;
  bit          first_wr = 1'b0;

  // Every memory write seen on the bus, in order.
  logic [31:0] log_data[$];
  int          log_addr[$];

  imem_loader #(
    .DEPTH      (DEPTH),
    .ADDR_W     (ADDR_W),
    .HALT_OPCODE(7'b1111111)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .cpu_stall (cpu_stall),
    .done      (done),
    .overflow  (overflow),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wr_en) begin
      log_addr.push_back(int'(wr_addr));
      log_data.push_back(wr_data);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    in_valid = (pos < stream.size()) && (!toggle || (cyc % 2 == 0));
    in_data  = (pos < stream.size()) ? stream[pos] : 8'h00;
  endtask

  task automatic step();
    logic hs;
    hs = in_valid && in_ready;
    @(posedge clk);
    #1;
    cyc++;
    if (hs) pos++;
    drive();
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int b = 0; b < 4; b++) stream.push_back(w[8*b +: 8]);
  endtask

  task automatic new_stream();
    stream.delete();
    log_addr.delete();
    log_data.delete();
    pos = 0;
    first_wr = 1'b0;
  endtask

  // Pulse start, run until done (bounded), return edges counted from start.
  task automatic run_load(input int max_cyc, input int glitch_at, output int n);
    start = 1'b1;
    drive();
    step();
    start = 1'b0;
    n = 1;
    while (!done && n < max_cyc) begin
      start = (n == glitch_at);
      step();
      n++;
      if (wr_en && pos > 0 && !first_wr) begin
        first_wr = 1'b1;
        chk("wr_after_4th_byte", 32'(pos), 32'd4);
      end
    end
    start = 1'b0;
    chk("load_done", 32'(done), 32'd1);
  endtask

  task automatic chk_clear();
    for (int i = 0; i < CLR; i++) begin
      chk("clear_addr", 32'(log_addr[i]), 32'(i));
      chk("clear_data", log_data[i], 32'h0);
    end
  endtask

  initial begin
    int n;
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    step();
    step();
    reset = 1'b0;
    step();

    // Reset state
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_cpu_stall", 32'(cpu_stall), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", wr_data, 32'd0);
    chk("rst_word_count", 32'(word_count), 32'd0);

    // Valid bytes without start are not consumed
    new_stream();
    push_word(32'h00A50033);
    push_word(32'h0000007F);
    drive();
    for (int i = 0; i < 3; i++) step();
    chk("idle_no_consume", 32'(pos), 32'd0);
    chk("idle_in_ready", 32'(in_ready), 32'd0);
    chk("idle_no_write", 32'(log_data.size()), 32'd0);

    // Two-word image ending in a halt word
    run_load(100, -1, n);
    chk("t1_latency", 32'(n), 32'(11 + CLR));
    chk_clear();
    chk("t1_writes", 32'(log_data.size()), 32'(2 + CLR));
    chk("t1_w0_addr", 32'(log_addr[CLR]), 32'd0);
    chk("t1_w0_data", log_data[CLR], 32'h00A50033);
    chk("t1_w1_addr", 32'(log_addr[CLR + 1]), 32'd1);
    chk("t1_w1_data", log_data[CLR + 1], 32'h0000007F);
    chk("t1_word_count", 32'(word_count), 32'd2);
    chk("t1_cpu_stall", 32'(cpu_stall), 32'd0);
    chk("t1_overflow", 32'(overflow), 32'd0);
    chk("t1_in_ready", 32'(in_ready), 32'd0);

    // Backpressure with in_valid toggling, plus an ignored mid-word start
    new_stream();
    push_word(32'h00000513);
    push_word(32'hFFFFFFFF);
    toggle = 1'b1;
    run_load(200, CLR + 4, n);
    toggle = 1'b0;
    chk_clear();
    chk("t2_writes", 32'(log_data.size()), 32'(2 + CLR));
    chk("t2_w0_addr", 32'(log_addr[CLR]), 32'd0);
    chk("t2_w0_data", log_data[CLR], 32'h00000513);
    chk("t2_w1_addr", 32'(log_addr[CLR + 1]), 32'd1);
    chk("t2_w1_data", log_data[CLR + 1], 32'hFFFFFFFF);
    chk("t2_word_count", 32'(word_count), 32'd2);
    chk("t2_overflow", 32'(overflow), 32'd0);

    // Overflow: four non-halt words fill memory, a fifth is never taken
    new_stream();
    for (int w = 0; w < 5; w++) push_word(32'h00000010 + 32'(w));
    run_load(200, -1, n);
    chk("t3_latency", 32'(n), 32'(21 + CLR));
    chk("t3_overflow", 32'(overflow), 32'd1);
    chk("t3_word_count", 32'(word_count), 32'd4);
    chk("t3_wr_addr", 32'(wr_addr), 32'd3);
    chk("t3_writes", 32'(log_data.size()), 32'(4 + CLR));
    for (int w = 0; w < 4; w++) begin
      chk("t3_addr", 32'(log_addr[CLR + w]), 32'(w));
      chk("t3_data", log_data[CLR + w], 32'h00000010 + 32'(w));
    end
    for (int i = 0; i < 3; i++) step();
    chk("t3_consumed", 32'(pos), 32'd16);
    chk("t3_in_ready", 32'(in_ready), 32'd0);
    chk("t3_done_sticky", 32'(done), 32'd1);

    // Reset after two bytes of word 3, then reload from address 0
    new_stream();
    for (int w = 0; w < 4; w++) push_word(32'h00000020 + 32'(w));
    start = 1'b1;
    drive();
    step();
    start = 1'b0;
    n = 0;
    while (pos < 14 && n < 200) begin
      step();
      n++;
    end
    chk("t4_reached_byte14", 32'(pos), 32'd14);
    chk("t4_count_before", 32'(word_count), 32'd3);
    chk("t4_stall_before", 32'(cpu_stall), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t4_word_count", 32'(word_count), 32'd0);
    chk("t4_in_ready", 32'(in_ready), 32'd0);
    chk("t4_cpu_stall", 32'(cpu_stall), 32'd0);
    chk("t4_wr_addr", 32'(wr_addr), 32'd0);
    chk("t4_wr_en", 32'(wr_en), 32'd0);

    new_stream();
    push_word(32'h0000007F);
    run_load(100, -1, n);
    chk("t4_latency", 32'(n), 32'(6 + CLR));
    chk_clear();
    chk("t4_writes", 32'(log_data.size()), 32'(1 + CLR));
    chk("t4_w0_addr", 32'(log_addr[CLR]), 32'd0);
    chk("t4_w0_data", log_data[CLR], 32'h0000007F);
    chk("t4_reload_count", 32'(word_count), 32'd1);
    chk("t4_reload_overflow", 32'(overflow), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
